// File: rtl/mux_4x1_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the mux_4x1 select arbiter.
// The master side drives requests; the slave side (the arbiter) returns grant and select.
interface mux_4x1_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       sel0;
    logic       sel1;
    logic       busy;

    modport master (
        output req,
        input  gnt,
        input  sel0,
        input  sel1,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output sel0,
        output sel1,
        output busy
    );
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter driving the mux_4x1 select pair; grant held per transaction.
// Optional hold-limit preemption is compiled in with `define MUX_ARB_HOLD_LIMIT_EN.
module mux_4x1_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input logic                  clk,
    input logic                  rst,
    mux_4x1_rr_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;

    // Returns {found, index} of the first set bit searching upward from start, modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0] pick_idle;
    logic [2:0] pick_next;
    logic [1:0] ptr_next;

    assign ptr_next  = sel_q + 2'd1;
    assign pick_idle = rr_pick(bus.req, ptr_q);
    // Excluding the holder covers both release (its bit is already low) and preemption.
    assign pick_next = rr_pick(bus.req & ~gnt_q, ptr_next);

`ifdef MUX_ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    localparam logic [CNT_W-1:0] HcntLast = CNT_W'(MAX_HOLD - 1);
`else
    logic unused_cfg;
    assign unused_cfg = ^{MAX_HOLD[0], CNT_W[0]};
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef MUX_ARB_HOLD_LIMIT_EN
        hcnt_d  = hcnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_idle[2]) begin
                    state_d = StGrant;
                    gnt_d   = 4'b0001 << pick_idle[1:0];
                    sel_d   = pick_idle[1:0];
`ifdef MUX_ARB_HOLD_LIMIT_EN
                    hcnt_d  = '0;
`endif
                end
            end
            StGrant: begin
                if (!bus.req[sel_q]) begin
                    ptr_d = ptr_next;
                    if (pick_next[2]) begin
                        gnt_d = 4'b0001 << pick_next[1:0];
                        sel_d = pick_next[1:0];
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                    end
`ifdef MUX_ARB_HOLD_LIMIT_EN
                    hcnt_d = '0;
`endif
                end
`ifdef MUX_ARB_HOLD_LIMIT_EN
                else if (hcnt_q == HcntLast) begin
                    // Tenure exhausted: hand over if anyone else waits, else restart the count.
                    hcnt_d = '0;
                    if (pick_next[2]) begin
                        ptr_d = ptr_next;
                        gnt_d = 4'b0001 << pick_next[1:0];
                        sel_d = pick_next[1:0];
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hcnt_q  <= hcnt_d;
`endif
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel0 = sel_q[0];
    assign bus.sel1 = sel_q[1];
    assign bus.busy = |gnt_q;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed bench for mux_4x1_rr_arbiter with hand-computed grant/select expectations.
module tb_mux_4x1_rr_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mux_4x1_rr_arbiter_if bus_if ();

    mux_4x1_rr_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [3:0] q);
        rst        = r;
        bus_if.req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] es);
        logic [1:0] sel_obs;
        logic       busy_exp;
        sel_obs  = {bus_if.sel1, bus_if.sel0};
        busy_exp = (eg != 4'b0000);
        total++;
        assert (bus_if.gnt === eg) else begin
            bad++;
            $error("FAIL %s gnt got=%b exp=%b", tag, bus_if.gnt, eg);
        end
        total++;
        assert (sel_obs === es) else begin
            bad++;
            $error("FAIL %s sel got=%b exp=%b", tag, sel_obs, es);
        end
        total++;
        assert (bus_if.busy === busy_exp) else begin
            bad++;
            $error("FAIL %s busy got=%b exp=%b", tag, bus_if.busy, busy_exp);
        end
    endtask

    initial begin
        logic [3:0] eg;
        logic [1:0] es;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        bus_if.req = 4'b0000;

        // Reset with all requests high.
        step(1'b1, 4'b1111); check("rst_c0", 4'b0000, 2'b00);
        step(1'b1, 4'b1111); check("rst_c1", 4'b0000, 2'b00);
        step(1'b0, 4'b1111); check("rst_rel", 4'b0001, 2'b00);

        // Round-robin with each holder dropping for one cycle.
        step(1'b0, 4'b1111); check("rr_hold0", 4'b0001, 2'b00);
        step(1'b0, 4'b1110); check("rr_to1", 4'b0010, 2'b01);
        step(1'b0, 4'b1111); check("rr_hold1", 4'b0010, 2'b01);
        step(1'b0, 4'b1101); check("rr_to2", 4'b0100, 2'b10);
        step(1'b0, 4'b1111); check("rr_hold2", 4'b0100, 2'b10);
        step(1'b0, 4'b1011); check("rr_to3", 4'b1000, 2'b11);
        step(1'b0, 4'b1111); check("rr_hold3", 4'b1000, 2'b11);
        step(1'b0, 4'b0111); check("rr_wrap0", 4'b0001, 2'b00);

        // Release with nobody else pending goes idle; ptr becomes 1.
        step(1'b0, 4'b0000); check("idle", 4'b0000, 2'b00);

        // Single requester 2 for five cycles, then drop (ptr becomes 3).
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0100); check($sformatf("single_%0d", i), 4'b0100, 2'b10);
        end
        step(1'b0, 4'b0000); check("single_drop", 4'b0000, 2'b10);

        // Zero-bubble handover from requester 1 to 0 (ptr 3 -> 2).
        step(1'b0, 4'b0010); check("zb_gnt1", 4'b0010, 2'b01);
        step(1'b0, 4'b0011); check("zb_hold1", 4'b0010, 2'b01);
        step(1'b0, 4'b0001); check("zb_to0", 4'b0001, 2'b00);

        // Move ptr to 0: hand to 3, then 3 drops to idle.
        step(1'b0, 4'b1000); check("pre_to3", 4'b1000, 2'b11);
        step(1'b0, 4'b0000); check("pre_idle", 4'b0000, 2'b11);

        // Hold-limit behaviour with requesters 0 and 3 constantly pending.
        for (int i = 0; i < 9; i++) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
            eg = (i >= 4 && i < 8) ? 4'b1000 : 4'b0001;
            es = (i >= 4 && i < 8) ? 2'b11 : 2'b00;
`else
            eg = 4'b0001;
            es = 2'b00;
`endif
            step(1'b0, 4'b1001); check($sformatf("hold_%0d", i), eg, es);
        end

        // Reset mid-grant: holder 3 with ptr at 1.
        step(1'b0, 4'b1000); check("mid_to3", 4'b1000, 2'b11);
        step(1'b1, 4'b1001); check("mid_rst", 4'b0000, 2'b00);
        // ptr cleared to 0, so requester 0 wins over 3.
        step(1'b0, 4'b1001); check("mid_rel_ptr", 4'b0001, 2'b00);
        step(1'b0, 4'b1000); check("mid_to3b", 4'b1000, 2'b11);
        step(1'b1, 4'b1000); check("mid_rst2", 4'b0000, 2'b00);
        step(1'b0, 4'b1000); check("mid_rel3", 4'b1000, 2'b11);
        step(1'b0, 4'b0000); check("end_idle", 4'b0000, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
